uart_tx_arbiter: RTL

Round-robin arbiter that shares one 8-bit UART transmitter among `NUM_REQ` byte requesters. It sits between the requesters and the transmitter's `tx_start` / `data_in` / `tx_busy` handshake and launches one byte at a time. A requester can lock the grant across a multi-byte message, so its bytes are sent without interleaving. A timeout releases an abandoned lock.

---
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART transmitter among NUM_REQ requesters.
// A requester can lock the grant for a multi-byte message; an idle lock is dropped after LOCK_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked,
  output logic                       lock_tmo,
  output logic                       tx_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMO_LAST  = TW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam logic [IDW-1:0] GRANT_RST = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_BUSY = 2'd1, WAIT_DONE = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic               locked_q, locked_d;
  logic               lock_tmo_q, lock_tmo_d;
  logic               tx_err_q, tx_err_d;
  logic [1:0]         wb_cnt_q, wb_cnt_d;
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;

  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] elig;
  logic               owner_req;
  logic               any_elig;
  logic [IDW-1:0]     pick;
  logic [7:0]         pick_data;
  logic               launch;

  // While locked only the current owner may compete.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
    assign owner_oh[gi] = (grant_q == IDW'(gi));
    assign elig[gi]     = req[gi] & (~locked_q | owner_oh[gi]);
  end

  assign owner_req = |(req & owner_oh);

  // Search order starts just after the last grant and wraps.
  always_comb begin
    int idx;
    idx       = 0;
    any_elig  = 1'b0;
    pick      = grant_q;
    pick_data = 8'h00;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(grant_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_elig && (i == idx) && elig[i]) begin
          any_elig = 1'b1;
          pick     = IDW'(i);
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDW'(i)) pick_data = req_data[8*i +: 8];
    end
  end

  assign launch = any_elig && !tx_busy && ((state_q == IDLE) || (state_q == WAIT_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_ack_q  <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      grant_q    <= GRANT_RST;
      locked_q   <= 1'b0;
      lock_tmo_q <= 1'b0;
      tx_err_q   <= 1'b0;
      wb_cnt_q   <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_ack_q  <= req_ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      locked_q   <= locked_d;
      lock_tmo_q <= lock_tmo_d;
      tx_err_q   <= tx_err_d;
      wb_cnt_q   <= wb_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (launch) state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)                state_d = WAIT_DONE;
        else if (wb_cnt_q == 2'd3)  state_d = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_d = launch ? WAIT_BUSY : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ack_d  = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    locked_d   = locked_q;
    lock_tmo_d = 1'b0;
    tx_err_d   = 1'b0;
    wb_cnt_d   = '0;
    tmo_cnt_d  = '0;

    if (launch) begin
      tx_start_d = 1'b1;
      req_ack_d  = NUM_REQ'(1) << pick;
      tx_data_d  = pick_data;
      grant_d    = pick;
      locked_d   = ~req_last[pick];
    end

    // The transmitter gets four cycles to acknowledge a launch by raising busy.
    if ((state_q == WAIT_BUSY) && !tx_busy) begin
      if (wb_cnt_q == 2'd3) begin
        tx_err_d = 1'b1;
        locked_d = 1'b0;
      end else begin
        wb_cnt_d = wb_cnt_q + 2'd1;
      end
    end

    if ((LOCK_TIMEOUT != 0) && locked_q && (state_q == IDLE) && !owner_req) begin
      if (tmo_cnt_q == TMO_LAST) begin
        locked_d   = 1'b0;
        lock_tmo_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
    end
  end

  assign req_ack  = req_ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign locked   = locked_q;
  assign lock_tmo = lock_tmo_q;
  assign tx_err   = tx_err_q;

endmodule
